// File: rtl/rc4_pkg.sv
// -----------------------------------------------------------------------------
// rc4_pkg
// Shared RC4 definitions: S-box size, key length, default message length,
// top-level and swap-sequencer state encodings, swap result payload and a
// key-byte selector.
// -----------------------------------------------------------------------------
package rc4_pkg;

  localparam int unsigned SBOX_SIZE       = 256;
  localparam int unsigned KEY_LEN         = 3;
  localparam int unsigned MSG_LEN_DEFAULT = 32;
  localparam int unsigned BYTE_W          = 8;
  localparam int unsigned KEY_W           = BYTE_W * KEY_LEN;

  // Top-level phases IDLE/FILL/KSA/PRGA/DONE with their sub-states
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FILL,
    ST_KSA_REQ,
    ST_KSA_WAIT,
    ST_PRGA_REQ,
    ST_PRGA_WAIT,
    ST_PRGA_WTF,
    ST_PRGA_WR,
    ST_PRGA_NEXT,
    ST_DONE
  } rc4_state_e;

  // Swap sequencer: read S[i], wait, read S[j], wait, write S[i], write S[j]
  typedef enum logic [2:0] {
    SW_IDLE,
    SW_WTI,
    SW_RDJ,
    SW_WTJ,
    SW_WRI,
    SW_WRJ,
    SW_DN
  } swap_state_e;

  // Result handed back on ack: updated j and the pre-swap S[i], S[j]
  typedef struct packed {
    logic [BYTE_W-1:0] j;
    logic [BYTE_W-1:0] si;
    logic [BYTE_W-1:0] sj;
  } swap_rsp_t;

  // Key byte 0 lives in the most significant byte
  function automatic logic [BYTE_W-1:0] key_byte(input logic [KEY_W-1:0] key,
                                                 input logic [1:0]       idx);
    case (idx)
      2'd0:    return key[23:16];
      2'd1:    return key[15:8];
      default: return key[7:0];
    endcase
  endfunction

endpackage

// File: rtl/rc4_swap.sv
// -----------------------------------------------------------------------------
// rc4_swap
// Shared S-box swap sequencer. On i_req it reads S[i], forms
// j' = i_j + S[i] + i_add (mod 256), reads S[j'], then writes S[i] <= old S[j']
// and S[j'] <= old S[i]. o_ack pulses for one cycle while the final write is on
// the RAM port; o_rsp carries j' and the two pre-swap values.
// Ports: clk, reset (async, high); i_req, i_i, i_j, i_add; o_ack, o_rsp;
//        RAM port o_address, o_data, o_wren, i_q (1-cycle read latency).
// -----------------------------------------------------------------------------
module rc4_swap
  import rc4_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [BYTE_W-1:0] i_i,
  input  logic [BYTE_W-1:0] i_j,
  input  logic [BYTE_W-1:0] i_add,
  input  logic [BYTE_W-1:0] i_q,
  output logic              o_ack,
  output swap_rsp_t         o_rsp,
  output logic [BYTE_W-1:0] o_address,
  output logic [BYTE_W-1:0] o_data,
  output logic              o_wren
);

  swap_state_e       r_state;
  logic [BYTE_W-1:0] r_si;
  logic [BYTE_W-1:0] r_sj;
  logic [BYTE_W-1:0] r_j;
  logic [BYTE_W-1:0] r_address;
  logic [BYTE_W-1:0] r_data;
  logic              r_wren;
  logic              r_ack;
  logic [BYTE_W-1:0] w_j_new;

  assign w_j_new = BYTE_W'(i_j + i_q + i_add);

  // Sequencer; both reads complete before either write is issued
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= SW_IDLE;
      r_si      <= '0;
      r_sj      <= '0;
      r_j       <= '0;
      r_address <= '0;
      r_data    <= '0;
      r_wren    <= 1'b0;
      r_ack     <= 1'b0;
    end else begin
      case (r_state)
        SW_IDLE: begin
          if (i_req) begin
            r_address <= i_i;
            r_state   <= SW_WTI;
          end
        end
        SW_WTI: r_state <= SW_RDJ;
        SW_RDJ: begin
          r_si      <= i_q;
          r_j       <= w_j_new;
          r_address <= w_j_new;
          r_state   <= SW_WTJ;
        end
        SW_WTJ: r_state <= SW_WRI;
        SW_WRI: begin
          r_sj      <= i_q;
          r_address <= i_i;
          r_data    <= i_q;
          r_wren    <= 1'b1;
          r_state   <= SW_WRJ;
        end
        SW_WRJ: begin
          r_address <= r_j;
          r_data    <= r_si;
          r_ack     <= 1'b1;
          r_state   <= SW_DN;
        end
        SW_DN: begin
          r_address <= '0;
          r_data    <= '0;
          r_wren    <= 1'b0;
          r_ack     <= 1'b0;
          r_state   <= SW_IDLE;
        end
        default: r_state <= SW_IDLE;
      endcase
    end
  end

  assign o_ack     = r_ack;
  assign o_rsp     = '{j: r_j, si: r_si, sj: r_sj};
  assign o_address = r_address;
  assign o_data    = r_data;
  assign o_wren    = r_wren;

endmodule

// File: rtl/rc4_encrypt.sv
// -----------------------------------------------------------------------------
// rc4_encrypt
// RC4 encryptor over external memories: fills the S-box, runs the key
// schedule, then generates MSG_LEN keystream bytes and writes c[k] = f ^ p[k].
// Start-to-done latency (start edge to the edge raising done) is
// 256 + 8*256 + 11*MSG_LEN = 2304 + 11*MSG_LEN cycles.
// Ports: clk, reset (async, high), start, secret_key[23:0];
//        S-box RAM address/data/wren/q; plaintext ROM address_p/q_p;
//        ciphertext RAM address_c/data_c/wren_c; status busy, done.
// -----------------------------------------------------------------------------
module rc4_encrypt
  import rc4_pkg::*;
#(
  parameter int unsigned MSG_LEN = MSG_LEN_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [KEY_W-1:0]  secret_key,
  output logic [BYTE_W-1:0] address,
  output logic [BYTE_W-1:0] data,
  output logic              wren,
  input  logic [BYTE_W-1:0] q,
  output logic [BYTE_W-1:0] address_p,
  input  logic [BYTE_W-1:0] q_p,
  output logic [BYTE_W-1:0] address_c,
  output logic [BYTE_W-1:0] data_c,
  output logic              wren_c,
  output logic              busy,
  output logic              done
);

  localparam logic [BYTE_W-1:0] LAST_K = BYTE_W'(MSG_LEN - 1);

  rc4_state_e        r_state;
  logic [KEY_W-1:0]  r_key;
  logic [BYTE_W-1:0] r_i;
  logic [BYTE_W-1:0] r_j;
  logic [BYTE_W-1:0] r_k;
  logic [1:0]        r_kidx;
  logic              r_req;
  logic              r_sel_swap;
  logic [BYTE_W-1:0] r_address;
  logic [BYTE_W-1:0] r_data;
  logic              r_wren;
  logic [BYTE_W-1:0] r_address_p;
  logic [BYTE_W-1:0] r_address_c;
  logic [BYTE_W-1:0] r_data_c;
  logic              r_wren_c;
  logic              r_busy;
  logic              r_done;

  logic [BYTE_W-1:0] w_add;
  logic              w_ack;
  swap_rsp_t         w_rsp;
  logic [BYTE_W-1:0] w_sw_address;
  logic [BYTE_W-1:0] w_sw_data;
  logic              w_sw_wren;

  // Key byte is added to j only during the key schedule
  assign w_add = (r_state == ST_KSA_WAIT) ? key_byte(r_key, r_kidx) : '0;

  rc4_swap u_swap (
    .clk       (clk),
    .reset     (reset),
    .i_req     (r_req),
    .i_i       (r_i),
    .i_j       (r_j),
    .i_add     (w_add),
    .i_q       (q),
    .o_ack     (w_ack),
    .o_rsp     (w_rsp),
    .o_address (w_sw_address),
    .o_data    (w_sw_data),
    .o_wren    (w_sw_wren)
  );

  // S-box port belongs to the swap sequencer while a swap is in flight
  assign address   = r_sel_swap ? w_sw_address : r_address;
  assign data      = r_sel_swap ? w_sw_data    : r_data;
  assign wren      = r_sel_swap ? w_sw_wren    : r_wren;
  assign address_p = r_address_p;
  assign address_c = r_address_c;
  assign data_c    = r_data_c;
  assign wren_c    = r_wren_c;
  assign busy      = r_busy;
  assign done      = r_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_key       <= '0;
      r_i         <= '0;
      r_j         <= '0;
      r_k         <= '0;
      r_kidx      <= '0;
      r_req       <= 1'b0;
      r_sel_swap  <= 1'b0;
      r_address   <= '0;
      r_data      <= '0;
      r_wren      <= 1'b0;
      r_address_p <= '0;
      r_address_c <= '0;
      r_data_c    <= '0;
      r_wren_c    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_key   <= secret_key;
            r_busy  <= 1'b1;
            r_i     <= '0;
            r_j     <= '0;
            r_k     <= '0;
            r_kidx  <= '0;
            r_state <= ST_FILL;
          end
        end
        // S[i] = i; i wraps back to 0 after 255
        ST_FILL: begin
          r_address <= r_i;
          r_data    <= r_i;
          r_wren    <= 1'b1;
          r_i       <= r_i + 8'd1;
          if (r_i == 8'hFF) r_state <= ST_KSA_REQ;
        end
        ST_KSA_REQ: begin
          r_wren     <= 1'b0;
          r_address  <= '0;
          r_data     <= '0;
          r_sel_swap <= 1'b1;
          r_req      <= 1'b1;
          r_state    <= ST_KSA_WAIT;
        end
        ST_KSA_WAIT: begin
          r_req <= 1'b0;
          if (w_ack) begin
            r_j    <= w_rsp.j;
            r_i    <= r_i + 8'd1;
            r_kidx <= (r_kidx == 2'd2) ? 2'd0 : r_kidx + 2'd1;
            if (r_i == 8'hFF) begin
              r_j     <= '0;
              r_state <= ST_PRGA_REQ;
            end else begin
              r_state <= ST_KSA_REQ;
            end
          end
        end
        ST_PRGA_REQ: begin
          r_i        <= r_i + 8'd1;
          r_req      <= 1'b1;
          r_sel_swap <= 1'b1;
          r_state    <= ST_PRGA_WAIT;
        end
        // Post-swap S[i]+S[j] equals the pre-swap sum, so either order works
        ST_PRGA_WAIT: begin
          r_req <= 1'b0;
          if (w_ack) begin
            r_j         <= w_rsp.j;
            r_sel_swap  <= 1'b0;
            r_address   <= BYTE_W'(w_rsp.si + w_rsp.sj);
            r_address_p <= r_k;
            r_state     <= ST_PRGA_WTF;
          end
        end
        ST_PRGA_WTF: r_state <= ST_PRGA_WR;
        ST_PRGA_WR: begin
          r_data_c    <= q ^ q_p;
          r_address_c <= r_k;
          r_wren_c    <= 1'b1;
          r_state     <= ST_PRGA_NEXT;
        end
        ST_PRGA_NEXT: begin
          r_wren_c <= 1'b0;
          if (r_k == LAST_K) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_DONE;
          end else begin
            r_k     <= r_k + 8'd1;
            r_state <= ST_PRGA_REQ;
          end
        end
        ST_DONE: begin
          r_done      <= 1'b0;
          r_address   <= '0;
          r_address_p <= '0;
          r_i         <= '0;
          r_j         <= '0;
          r_k         <= '0;
          r_state     <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rc4_encrypt.sv
// -----------------------------------------------------------------------------
// tb_rc4_encrypt
// Self-checking bench: two instances (MSG_LEN=32 and MSG_LEN=1) with memory
// models, a behavioural RC4 reference, and directed/randomised scenarios.
// -----------------------------------------------------------------------------
module tb_rc4_encrypt;

  localparam int M0       = 32;
  localparam int BASE_CYC = 2304;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, start1;
  logic [23:0] secret_key;

  logic [7:0] address, data, q = 8'd0, address_p, q_p = 8'd0, address_c, data_c;
  logic       wren, wren_c, busy, done;
  logic [7:0] address1, data1, q1 = 8'd0, address_p1, q_p1 = 8'd0, address_c1, data_c1;
  logic       wren1, wren_c1, busy1, done1;

  logic [7:0] sbox0 [256];
  logic [7:0] sbox1 [256];
  logic [7:0] pt    [256];
  logic [7:0] ct0   [256];
  logic [7:0] ct1   [256];
  logic [7:0] exp_ct[256];
  logic [7:0] msg   [256];

  int n_tests = 0;
  int n_fail  = 0;

  int run_cyc, run_cyc1, run_nwc, run_nwc1, run_ndone, run_bad, run_bad1, run_busy_bad;

  rc4_encrypt #(.MSG_LEN(M0)) u_dut (
    .clk(clk), .reset(reset), .start(start), .secret_key(secret_key),
    .address(address), .data(data), .wren(wren), .q(q),
    .address_p(address_p), .q_p(q_p),
    .address_c(address_c), .data_c(data_c), .wren_c(wren_c),
    .busy(busy), .done(done)
  );

  rc4_encrypt #(.MSG_LEN(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .secret_key(secret_key),
    .address(address1), .data(data1), .wren(wren1), .q(q1),
    .address_p(address_p1), .q_p(q_p1),
    .address_c(address_c1), .data_c(data_c1), .wren_c(wren_c1),
    .busy(busy1), .done(done1)
  );

  // Memory models: synchronous read returning pre-write contents
  always @(posedge clk) begin
    q   <= sbox0[address];
    q_p <= pt[address_p];
    if (wren)   sbox0[address] = data;
    if (wren_c) ct0[address_c] = data_c;
  end

  always @(posedge clk) begin
    q1   <= sbox1[address1];
    q_p1 <= pt[address_p1];
    if (wren1)   sbox1[address1] = data1;
    if (wren_c1) ct1[address_c1] = data_c1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
    end
  endtask

  // Textbook RC4 over plain integer arrays
  function automatic void rc4_model(input logic [23:0] key, input int n);
    int s[256];
    int i, j, t, kb;
    logic [23:0] sh;
    for (int a = 0; a < 256; a++) s[a] = a;
    j = 0;
    for (int a = 0; a < 256; a++) begin
      sh = key >> (8 * (2 - (a % 3)));
      kb = int'(sh[7:0]);
      j = (j + s[a] + kb) % 256;
      t = s[a]; s[a] = s[j]; s[j] = t;
    end
    i = 0; j = 0;
    for (int k = 0; k < n; k++) begin
      i = (i + 1) % 256;
      j = (j + s[i]) % 256;
      t = s[i]; s[i] = s[j]; s[j] = t;
      exp_ct[k] = 8'(s[(s[i] + s[j]) % 256]) ^ pt[k];
    end
  endfunction

  // One run: optional extra start pulse at edge pulse_at; use1 also starts u_dut1
  task automatic run(input logic [23:0] key, input int pulse_at, input bit use1);
    run_cyc = -1; run_cyc1 = -1; run_nwc = 0; run_nwc1 = 0;
    run_ndone = 0; run_bad = 0; run_bad1 = 0; run_busy_bad = 0;
    for (int a = 0; a < 256; a++) begin ct0[a] = 'x; ct1[a] = 'x; end
    secret_key = key;
    @(negedge clk); start = 1'b1; start1 = use1;
    @(negedge clk); start = 1'b0; start1 = 1'b0;
    for (int e = 1; e <= 4000; e++) begin
      @(posedge clk); #1;
      if (start) start = 1'b0;
      if (e == pulse_at) start = 1'b1;
      if (e == 1 && !busy) run_busy_bad++;
      if (wren_c) begin
        if (address_c !== 8'(run_nwc)) run_bad++;
        run_nwc++;
      end
      if (wren_c1) begin
        if (address_c1 !== 8'd0) run_bad1++;
        run_nwc1++;
      end
      if (done1 && run_cyc1 < 0) run_cyc1 = e;
      if (done) begin
        run_ndone++;
        if (run_cyc < 0) run_cyc = e;
        if (busy || wren || wren_c) run_busy_bad++;
      end
      if (run_cyc >= 0 && e >= run_cyc + 16) break;
    end
  endtask

  task automatic check_run(input string tag, input int m);
    int bad = 0;
    for (int k = 0; k < m; k++) if (ct0[k] !== exp_ct[k]) bad++;
    chk({tag, "_ct"}, 64'(bad), 64'd0);
    chk({tag, "_wren_c_pulses"}, 64'(run_nwc), 64'(m));
    chk({tag, "_done_pulses"}, 64'(run_ndone), 64'd1);
    chk({tag, "_address_c_seq"}, 64'(run_bad), 64'd0);
    chk({tag, "_busy_done"}, 64'(run_busy_bad), 64'd0);
    chk({tag, "_cycles"}, 64'(run_cyc), 64'(BASE_CYC + 11 * m));
  endtask

  logic [7:0] kv_p[9] = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
  logic [7:0] kv_c[9] = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};

  initial begin
    int          n_wr, bad;
    logic [23:0] key_r;

    reset = 1'b1; start = 1'b0; start1 = 1'b0; secret_key = 24'h0;
    for (int a = 0; a < 256; a++) begin
      sbox0[a] = 8'($urandom); sbox1[a] = 8'($urandom); pt[a] = 8'($urandom);
    end
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 64'({address, data, wren, address_p, address_c, data_c, wren_c, busy, done}), 64'd0);
    chk("reset_outputs_len1", 64'({address1, wren1, wren_c1, busy1, done1}), 64'd0);
    @(negedge clk); reset = 1'b0;

    // Fill phase, then reset in the middle of the key schedule (i=100)
    secret_key = 24'h4B6579;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n_wr = 0;
    for (int e = 1; e <= 1060; e++) begin
      @(posedge clk); #1;
      if (e <= 257 && wren) n_wr++;
      if (e == 257) begin
        bad = 0;
        for (int n = 0; n < 256; n++) if (sbox0[n] !== 8'(n)) bad++;
        chk("fill_sbox_identity", 64'(bad), 64'd0);
      end
    end
    chk("fill_wren_pulses", 64'(n_wr), 64'd256);
    chk("ksa_busy", 64'(busy), 64'd1);
    @(negedge clk); reset = 1'b1;
    #1;
    chk("midrun_reset_outputs", 64'({address, data, wren, address_p, address_c, data_c, wren_c, busy, done}), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    bad = 0;
    for (int e = 0; e < 30; e++) begin
      @(posedge clk); #1;
      if (busy || wren || wren_c || done) bad++;
    end
    chk("no_resume", 64'(bad), 64'd0);

    // Known vector after the interrupted run
    for (int k = 0; k < 9; k++) pt[k] = kv_p[k];
    rc4_model(24'h4B6579, M0);
    run(24'h4B6579, 0, 1'b0);
    for (int k = 0; k < 9; k++) chk($sformatf("kv_c%0d", k), 64'(ct0[k]), 64'(kv_c[k]));
    check_run("kv", M0);

    // Random key and message with a start pulse mid-PRGA, then round trip
    key_r = 24'($urandom);
    for (int k = 0; k < M0; k++) begin pt[k] = 8'($urandom); msg[k] = pt[k]; end
    rc4_model(key_r, M0);
    run(key_r, BASE_CYC + 11 * 5 + 3, 1'b0);
    check_run("rand_start_ignored", M0);
    for (int k = 0; k < M0; k++) pt[k] = ct0[k];
    run(key_r, 0, 1'b0);
    bad = 0;
    for (int k = 0; k < M0; k++) if (ct0[k] !== msg[k]) bad++;
    chk("round_trip", 64'(bad), 64'd0);

    // All-zero key; MSG_LEN=1 instance runs alongside
    for (int k = 0; k < M0; k++) pt[k] = 8'($urandom);
    rc4_model(24'h000000, M0);
    run(24'h000000, 0, 1'b1);
    check_run("zero_key", M0);
    chk("len1_wren_c_pulses", 64'(run_nwc1), 64'd1);
    chk("len1_address_c", 64'(run_bad1), 64'd0);
    chk("len1_cycles", 64'(run_cyc1), 64'(BASE_CYC + 11));
    chk("len1_ct0", 64'(ct1[0]), 64'(exp_ct[0]));

    // Repeat known vector: no state may carry over between runs
    for (int k = 0; k < 9; k++) pt[k] = kv_p[k];
    rc4_model(24'h4B6579, M0);
    run(24'h4B6579, 0, 1'b0);
    bad = 0;
    for (int k = 0; k < 9; k++) if (ct0[k] !== kv_c[k]) bad++;
    chk("kv_repeat", 64'(bad), 64'd0);
    check_run("kv_repeat", M0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
